// File: rtl/debug_slave_pkg.sv
// debug_slave_pkg: shared width helpers and default command entry layout for the debug slave
package debug_slave_pkg;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction
  function automatic int cmd_width(input int num_ch, input int ir_w, input int sr_w);
    return (num_ch > 1 ? clog2(num_ch) : 1) + ir_w + sr_w;
  endfunction
  localparam int NUM_CH_D = 2;
  localparam int IR_W_D = 2;
  localparam int SR_W_D = 38;
  localparam int CMD_W = cmd_width(NUM_CH_D, IR_W_D, SR_W_D);
  typedef struct packed {
    logic [clog2(NUM_CH_D)-1:0] ch;
    logic [IR_W_D-1:0] ir;
    logic [SR_W_D-1:0] data;
  } cmd_t;
endpackage

// File: rtl/debug_slave_cmd_fifo.sv
// debug_slave_cmd_fifo: show-ahead FIFO (push/din in, pop in, dout/valid/full/level out), registered pointers
module debug_slave_cmd_fifo
  import debug_slave_pkg::*;
#(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic          full,
  output logic [AW:0]   level
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  assign level = wptr - rptr;
  assign valid = level != '0;
  assign full = level == (AW+1)'(DEPTH);
  assign dout = mem[rptr[AW-1:0]];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= push ? wptr + 1'b1 : wptr;
      rptr <= pop ? rptr + 1'b1 : rptr;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/debug_slave_sysclk_mc.sv
// debug_slave_sysclk_mc: syncs per-channel vs_uir/vs_udr, captures ir_in/sr, round-robin into a FIFO; cmd_* valid/ready out, ovf/ovf_clr, fifo_level
module debug_slave_sysclk_mc
  import debug_slave_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int SR_W = 38,
  parameter int IR_W = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int CH_W = NUM_CH > 1 ? clog2(NUM_CH) : 1,
  localparam int LVL_W = clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      vs_uir,
  input  logic [NUM_CH-1:0]      vs_udr,
  input  logic [NUM_CH*IR_W-1:0] ir_in,
  input  logic [NUM_CH*SR_W-1:0] sr,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [CH_W-1:0]        cmd_ch,
  output logic [IR_W-1:0]        cmd_ir,
  output logic [SR_W-1:0]        cmd_data,
  output logic [(1<<IR_W)-1:0]   cmd_action,
  output logic [NUM_CH-1:0]      ovf,
  input  logic [NUM_CH-1:0]      ovf_clr,
  output logic [LVL_W-1:0]       fifo_level
);
  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int AW = clog2(ARM_MAX + 1);
  localparam int E_W = cmd_width(NUM_CH, IR_W, SR_W);
  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] data;
  } entry_t;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] uir_sync, udr_sync;
  logic [NUM_CH-1:0] uir_hist, udr_hist, uir_rise, udr_rise, pending, gnt_mask;
  logic [IR_W-1:0] ir_reg [NUM_CH];
  logic [IR_W-1:0] pend_ir [NUM_CH];
  logic [SR_W-1:0] data_reg [NUM_CH];
  logic [AW-1:0] arm_cnt;
  logic [CH_W-1:0] rr, gnt;
  logic armed, gnt_v, push, pop, full;
  entry_t din, head;
  assign armed = arm_cnt == AW'(ARM_MAX);
  assign uir_rise = armed ? uir_sync[SYNC_STAGES-1] & ~uir_hist : '0;
  assign udr_rise = armed ? udr_sync[SYNC_STAGES-1] & ~udr_hist : '0;
  always_comb begin
    gnt_v = 1'b0;
    gnt = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[CH_W'((int'(rr) + i) % NUM_CH)]) begin
        gnt_v = 1'b1;
        gnt = CH_W'((int'(rr) + i) % NUM_CH);
      end
    end
  end
  assign pop = cmd_valid & cmd_ready;
  assign push = gnt_v & (~full | pop);
  assign gnt_mask = push ? NUM_CH'(1) << gnt : '0;
  assign din = '{ch: gnt, ir: pend_ir[gnt], data: data_reg[gnt]};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uir_sync <= '0;
      udr_sync <= '0;
      uir_hist <= '0;
      udr_hist <= '0;
      arm_cnt <= '0;
      pending <= '0;
      ovf <= '0;
      rr <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        ir_reg[c] <= '0;
        pend_ir[c] <= '0;
        data_reg[c] <= '0;
      end
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_hist <= uir_sync[SYNC_STAGES-1];
      udr_hist <= udr_sync[SYNC_STAGES-1];
      arm_cnt <= armed ? arm_cnt : arm_cnt + 1'b1;
      rr <= push ? CH_W'((int'(gnt) + 1) % NUM_CH) : rr;
      pending <= (pending & ~gnt_mask) | udr_rise;
      ovf <= (ovf & ~ovf_clr) | (udr_rise & pending & ~gnt_mask);
      for (int c = 0; c < NUM_CH; c++) begin
        if (uir_rise[c]) ir_reg[c] <= ir_in[c*IR_W +: IR_W];
        if (udr_rise[c]) begin
          data_reg[c] <= sr[c*SR_W +: SR_W];
          pend_ir[c] <= ir_reg[c];
        end
      end
    end
  end
  debug_slave_cmd_fifo #(.W(E_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din(din),
    .pop(pop),
    .dout(head),
    .valid(cmd_valid),
    .full(full),
    .level(fifo_level)
  );
  assign cmd_ch = head.ch;
  assign cmd_ir = head.ir;
  assign cmd_data = head.data;
  assign cmd_action = cmd_valid ? (1 << IR_W)'(1) << head.ir : '0;
endmodule

// File: tb/tb_debug_slave_sysclk_mc.sv
// tb_debug_slave_sysclk_mc: scoreboard bench with directed and random traffic for debug_slave_sysclk_mc
module tb_debug_slave_sysclk_mc;
  localparam int NUM_CH = 2, SR_W = 38, IR_W = 2;
  logic clk = 1'b0, reset = 1'b1, cmd_valid, cmd_ready = 1'b0;
  logic [NUM_CH-1:0] vs_uir = '0, vs_udr = '0, ovf, ovf_clr = '0;
  logic [NUM_CH*IR_W-1:0] ir_in = '0;
  logic [NUM_CH*SR_W-1:0] sr = '0;
  logic [0:0] cmd_ch;
  logic [IR_W-1:0] cmd_ir;
  logic [SR_W-1:0] cmd_data;
  logic [3:0] cmd_action;
  logic [2:0] fifo_level;
  typedef struct {int ch; int ir; logic [SR_W-1:0] data;} exp_t;
  exp_t sb[$];
  int model_ir [NUM_CH] = '{0, 0};
  int total = 0, passed = 0;
  bit rnd = 0;
  debug_slave_sysclk_mc dut (
    .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in), .sr(sr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_ir(cmd_ir),
    .cmd_data(cmd_data), .cmd_action(cmd_action), .ovf(ovf), .ovf_clr(ovf_clr),
    .fifo_level(fifo_level)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end
  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h want %0h", n, a, e);
  endtask
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      int idx;
      idx = -1;
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].ch == int'(cmd_ch)) idx = i;
      if (idx < 0) check("unexpected_cmd", 64'(cmd_ch), 64'hFF);
      else begin
        check("cmd_ir", 64'(cmd_ir), 64'(sb[idx].ir));
        check("cmd_data", 64'(cmd_data), 64'(sb[idx].data));
        check("cmd_action", 64'(cmd_action), 64'(1) << sb[idx].ir);
        sb.delete(idx);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) cmd_ready = ($urandom_range(0, 3) != 0);
  endtask
  task automatic send(input int ch, input logic [IR_W-1:0] ir, input logic [SR_W-1:0] d, input bit exp);
    ir_in[ch*IR_W +: IR_W] = ir;
    model_ir[ch] = int'(ir);
    vs_uir[ch] = 1'b1;
    repeat (3) tick();
    vs_uir[ch] = 1'b0;
    tick();
    sr[ch*SR_W +: SR_W] = d;
    vs_udr[ch] = 1'b1;
    if (exp) sb.push_back('{ch, int'(ir), d});
    repeat (3) tick();
    vs_udr[ch] = 1'b0;
    repeat (2) tick();
  endtask
  task automatic pop1();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    cmd_ready = 1'b1;
    while (fifo_level != 0 && n < 60) begin
      tick();
      n++;
    end
    cmd_ready = 1'b0;
    check("drain_done", 64'(n < 60), 1);
    tick();
  endtask
  task automatic both(input int first);
    logic [SR_W-1:0] a, b;
    a = SR_W'({$urandom(), $urandom()});
    b = SR_W'({$urandom(), $urandom()});
    sr = {b, a};
    vs_udr = 2'b11;
    sb.push_back('{0, model_ir[0], a});
    sb.push_back('{1, model_ir[1], b});
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rr_first_ch", 64'(cmd_ch), 64'(first));
    check("rr_level1", 64'(fifo_level), 1);
    @(posedge clk);
    @(negedge clk);
    check("rr_level2", 64'(fifo_level), 2);
    tick();
    vs_udr = '0;
    tick();
    pop1();
    check("rr_second_ch", 64'(cmd_ch), 64'(1 - first));
    pop1();
  endtask
  initial begin
    bit seen;
    vs_udr[0] = 1'b1;
    repeat (2) tick();
    check("reset_valid", 64'(cmd_valid), 0);
    check("reset_action", 64'(cmd_action), 0);
    check("reset_level", 64'(fifo_level), 0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen |= cmd_valid;
    end
    check("held_strobe_no_cmd", 64'(seen), 0);
    check("held_strobe_ovf", 64'(ovf), 0);
    tick();
    vs_udr = '0;
    repeat (3) tick();
    ir_in[1:0] = 2'b01;
    model_ir[0] = 1;
    vs_uir[0] = 1'b1;
    repeat (3) tick();
    vs_uir[0] = 1'b0;
    repeat (2) tick();
    sr[SR_W-1:0] = 38'h2A_DEAD_BEEF;
    vs_udr[0] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 3) check("valid_edge3", 64'(cmd_valid), 0);
    end
    check("valid_edge4", 64'(cmd_valid), 1);
    check("lat_ch", 64'(cmd_ch), 0);
    check("lat_ir", 64'(cmd_ir), 1);
    check("lat_data", 64'(cmd_data), 64'h2A_DEAD_BEEF);
    check("lat_action", 64'(cmd_action), 64'b0010);
    tick();
    vs_udr[0] = 1'b0;
    sb.push_back('{0, 1, 38'h2A_DEAD_BEEF});
    tick();
    pop1();
    ir_in[3:2] = 2'b11;
    model_ir[1] = 3;
    vs_uir[1] = 1'b1;
    repeat (3) tick();
    vs_uir[1] = 1'b0;
    tick();
    both(1);
    send(1, 2'd3, SR_W'(7), 1);
    drain();
    both(0);
    send(0, 2'd0, SR_W'(11), 1);
    send(1, 2'd1, SR_W'(12), 1);
    send(0, 2'd2, SR_W'(13), 1);
    send(1, 2'd3, SR_W'(14), 1);
    send(0, 2'd1, SR_W'(15), 1);
    check("full_level", 64'(fifo_level), 4);
    check("full_ovf", 64'(ovf), 0);
    pop1();
    repeat (3) tick();
    check("refill_level", 64'(fifo_level), 4);
    drain();
    check("stall_no_ovf", 64'(ovf), 0);
    check("stall_sb_empty", 64'(sb.size()), 0);
    for (int i = 0; i < 4; i++) send(0, 2'd2, SR_W'(20 + i), 1);
    send(1, 2'd1, SR_W'(1), 0);
    send(1, 2'd1, SR_W'(2), 1);
    check("ovf_set", 64'(ovf), 2'b10);
    drain();
    ovf_clr = 2'b10;
    tick();
    ovf_clr = '0;
    check("ovf_clear", 64'(ovf), 0);
    for (int i = 0; i < 4; i++) send(0, 2'd3, SR_W'(30 + i), 1);
    send(1, 2'd1, SR_W'(3), 0);
    sr[SR_W +: SR_W] = SR_W'(4);
    vs_udr[1] = 1'b1;
    sb.push_back('{1, 1, SR_W'(4)});
    repeat (2) tick();
    ovf_clr = 2'b10;
    tick();
    ovf_clr = '0;
    check("ovf_set_wins", 64'(ovf), 2'b10);
    vs_udr[1] = 1'b0;
    repeat (2) tick();
    drain();
    for (int i = 0; i < 3; i++) send(i % 2, 2'd1, SR_W'(40 + i), 1);
    check("pre_reset_level", 64'(fifo_level), 3);
    vs_udr[1] = 1'b1;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_valid", 64'(cmd_valid), 0);
    check("reset_mid_level", 64'(fifo_level), 0);
    sb.delete();
    model_ir = '{0, 0};
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen |= cmd_valid;
    end
    check("no_stale_after_reset", 64'(seen), 0);
    check("reset_mid_ovf", 64'(ovf), 0);
    tick();
    vs_udr = '0;
    repeat (3) tick();
    rnd = 1;
    for (int i = 0; i < 24; i++) begin
      send(int'($urandom_range(0, 1)), IR_W'($urandom()), SR_W'({$urandom(), $urandom()}), 1);
      repeat ($urandom_range(0, 3)) tick();
    end
    rnd = 0;
    drain();
    check("random_sb_empty", 64'(sb.size()), 0);
    check("random_ovf", 64'(ovf), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/debug_slave_sysclk_mc.md
Name: debug_slave_sysclk_mc

Overview:
Multi-channel, parametrised system-clock side of the Nios II JTAG debug slave. It takes per-channel virtual-JTAG update strobes (vs_uir, vs_udr) and the instruction and shift registers (ir_in, sr), which are asynchronous to clk. It synchronises the strobes, captures each completed command and arbitrates channels round-robin into a command FIFO. Commands leave on a valid/ready interface with a one-hot action decode, replacing the fixed single-channel take_action_* fan-out.

Parameters:
NUM_CH, 2, number of virtual-JTAG channels (1..8)
SR_W, 38, shift-register/data width per channel
IR_W, 2, instruction-register width per channel
SYNC_STAGES, 2, synchroniser depth for vs_uir/vs_udr (2..4)
FIFO_DEPTH, 4, command FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
vs_uir  in  NUM_CH  per-channel update-IR level, async to clk
vs_udr  in  NUM_CH  per-channel update-DR level, async to clk
ir_in  in  NUM_CH*IR_W  per-channel IR, stable while vs_uir/vs_udr high
sr  in  NUM_CH*SR_W  per-channel shift register, stable while vs_udr high
cmd_valid  out  1  FIFO head valid
cmd_ready  in  1  consumer accepts head
cmd_ch  out  clog2(NUM_CH) (min 1)  channel of head
cmd_ir  out  IR_W  IR latched for head
cmd_data  out  SR_W  captured sr (jdo equivalent)
cmd_action  out  2**IR_W  one-hot of cmd_ir, gated by cmd_valid
ovf  out  NUM_CH  sticky per-channel overrun flag
ovf_clr  in  NUM_CH  per-bit clear pulse for ovf
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: all sync/edge flops, ir_reg, data_reg, pending, ovf, FIFO pointers, rr pointer = 0. cmd_valid = 0, cmd_action = 0, fifo_level = 0. Arm counter = 0.
- Arm counter: counts 0..SYNC_STAGES+1 after reset, then holds. Edge detection is masked until it saturates. Strobes already high at reset release create no command.
- Sync: each vs_uir/vs_udr bit passes through SYNC_STAGES flops plus one history flop. Rise = sync_out & ~hist.
- uir rise on ch: ir_reg[ch] <= ir_in[ch].
- udr rise on ch: data_reg[ch] <= sr[ch] and pending[ch] <= 1. If pending[ch] was already 1, new data overwrites (latest wins) and ovf[ch] <= 1.
- uir and udr rise on the same channel in the same cycle: the udr capture uses the previous ir_reg. The new IR applies to the next command.
- Arbiter: each cycle, if FIFO not full (or a pop occurs this cycle), grant the lowest-index pending channel at or after rr. Write {ch, ir_reg[ch], data_reg[ch]}, clear pending[ch], rr <= grant+1 mod NUM_CH.
- Grant plus new udr rise on the same channel in the same cycle: the entry is written with the old data and pending stays 1 with the new data. No overflow is flagged.
- Latency: first clk edge sampling vs_udr=1 is edge 1. pending sets at edge SYNC_STAGES+1, the FIFO write lands at edge SYNC_STAGES+2, and cmd_valid is high after that edge (4 edges at default).
- FIFO: show-ahead, registered pointers. Pop on cmd_valid & cmd_ready. Push and pop in the same cycle are legal when full or empty (empty: push only; head appears next cycle). Full with no pop: stall, pending holds.
- cmd_action = cmd_valid ? (1 << cmd_ir) : 0.
- ovf: a set and an ovf_clr in the same cycle leave the bit 1 (set wins).
- Reset mid-operation clears FIFO contents, pending and ovf. Partially synchronised strobes are discarded.

Decomposition:
- Shared package debug_slave_pkg: CMD_W = clog2(NUM_CH)+IR_W+SR_W, cmd entry struct {ch, ir, data}, and clog2 function.
- One sub-module, debug_slave_cmd_fifo: parametrised width/depth show-ahead FIFO with level output.
- Synchroniser and arbiter stay inline.

Test Plan:
- Reset release with vs_udr[0]=1 held -> no cmd_valid within 10 cycles, ovf=0.
- ch0: vs_uir with ir_in=2'b01, then vs_udr with sr=38'h2A_DEAD_BEEF -> cmd_valid at edge 4. cmd_ch=0, cmd_ir=1, cmd_data=38'h2A_DEAD_BEEF, cmd_action=4'b0010.
- ch0 and ch1 udr rise in the same cycle, rr=0 -> ch0 entry then ch1 entry on consecutive cycles, rr=0 after both.
- cmd_ready=0, five udr events spread across channels, FIFO_DEPTH=4 -> fifo_level=4. The fifth waits pending, enters after one pop, and ovf stays 0.
- Two udr rises on ch1 with the FIFO full (sr=1 then sr=2) -> ovf[1]=1 and the later entry's cmd_data=2. An ovf_clr[1] pulse coinciding with a third overrun leaves ovf[1]=1.
- Assert reset with 3 entries queued -> cmd_valid=0 and fifo_level=0 the next cycle, and no stale entry appears after release.
